// File: rtl/sram_rw_port_arbiter.sv
// Round-robin arbiter sharing the single RW port of a 1rw OpenRAM macro
// between requesters A and B, with optional post-reset zero-fill.
module sram_rw_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                  clk0,
    input  logic                  rst_n,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic                  init_done,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam state_t ST_RESET = INIT_EN ? S_INIT : S_RUN;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [ADDR_WIDTH-1:0]   w_cnt_nxt;
    logic                    w_init_wr;
    logic                    r_init_done;

    logic                    r_prio_b;
    logic                    w_run;
    logic                    w_a_gnt;
    logic                    w_b_gnt;

    logic                    r_csb;
    logic                    r_web;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_din;

    logic                    r_tag1_rd;
    logic                    r_tag1_b;
    logic                    r_tag2_rd;
    logic                    r_tag2_b;

    logic                    r_a_rvalid;
    logic                    r_b_rvalid;
    logic [DATA_WIDTH-1:0]   r_a_rdata;
    logic [DATA_WIDTH-1:0]   r_b_rdata;

    // State register and zero-fill address counter
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RESET;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_done <= (w_state_nxt == S_RUN);
        end
    end

    // Next state: walk every address once in INIT, then stay in RUN
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_init_wr   = 1'b0;
        unique case (r_state)
            S_INIT: begin
                w_init_wr = 1'b1;
                w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == '1) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
    end

    // Ready is combinational; r_prio_b picks the winner of a conflict
    assign w_run   = r_init_done;
    assign w_a_gnt = w_run && a_valid && (!b_valid || !r_prio_b);
    assign w_b_gnt = w_run && b_valid && (!a_valid ||  r_prio_b);

    // Pointer moves away from whoever was just granted
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_b <= 1'b0;
        end else if (w_a_gnt) begin
            r_prio_b <= 1'b1;
        end else if (w_b_gnt) begin
            r_prio_b <= 1'b0;
        end
    end

    // Registered macro command: zero-fill write, granted command or idle
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_csb  <= 1'b1;
            r_web  <= 1'b1;
            r_addr <= '0;
            r_din  <= '0;
        end else if (w_init_wr) begin
            r_csb  <= 1'b0;
            r_web  <= 1'b0;
            r_addr <= r_cnt;
            r_din  <= '0;
        end else if (w_a_gnt) begin
            r_csb  <= 1'b0;
            r_web  <= ~a_we;
            r_addr <= a_addr;
            r_din  <= a_wdata;
        end else if (w_b_gnt) begin
            r_csb  <= 1'b0;
            r_web  <= ~b_we;
            r_addr <= b_addr;
            r_din  <= b_wdata;
        end else begin
            r_csb  <= 1'b1;
            r_web  <= 1'b1;
        end
    end

    // Read tag rides two stages to line up with macro dout
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_tag1_rd <= 1'b0;
            r_tag1_b  <= 1'b0;
            r_tag2_rd <= 1'b0;
            r_tag2_b  <= 1'b0;
        end else begin
            r_tag1_rd <= (w_a_gnt && !a_we) || (w_b_gnt && !b_we);
            r_tag1_b  <= w_b_gnt;
            r_tag2_rd <= r_tag1_rd;
            r_tag2_b  <= r_tag1_b;
        end
    end

    // Capture dout for the tagged requester and pulse its rvalid
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            r_a_rvalid <= r_tag2_rd && !r_tag2_b;
            r_b_rvalid <= r_tag2_rd &&  r_tag2_b;
            if (r_tag2_rd && !r_tag2_b) begin
                r_a_rdata <= sram_dout0;
            end
            if (r_tag2_rd && r_tag2_b) begin
                r_b_rdata <= sram_dout0;
            end
        end
    end

    assign a_ready    = w_a_gnt;
    assign b_ready    = w_b_gnt;
    assign a_rvalid   = r_a_rvalid;
    assign b_rvalid   = r_b_rvalid;
    assign a_rdata    = r_a_rdata;
    assign b_rdata    = r_b_rdata;
    assign init_done  = r_init_done;
    assign sram_csb0  = r_csb;
    assign sram_web0  = r_web;
    assign sram_addr0 = r_addr;
    assign sram_din0  = r_din;

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// Directed bench for sram_rw_port_arbiter with a behavioural macro model
// and a scoreboard queue of expected read responses.
module tb_sram_rw_port_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int DEPTH = 1 << AW;

    logic          clk0 = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_valid = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          a_ready, a_rvalid, b_ready, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          init_done;
    logic          sram_csb0, sram_web0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0 = '0;

    typedef struct {
        bit            req;
        logic [DW-1:0] data;
        int            hs;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] mem [DEPTH];
    int            n_cmp = 0;
    int            n_mis = 0;
    int            cyc = 0;

    logic          m_csb = 1'b1, m_web = 1'b1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din = '0;

    sram_rw_port_arbiter dut (
        .clk0       (clk0),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_we       (a_we),
        .a_addr     (a_addr),
        .a_wdata    (a_wdata),
        .a_rvalid   (a_rvalid),
        .a_rdata    (a_rdata),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_we       (b_we),
        .b_addr     (b_addr),
        .b_wdata    (b_wdata),
        .b_rvalid   (b_rvalid),
        .b_rdata    (b_rdata),
        .init_done  (init_done),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0)
    );

    always #5 clk0 = ~clk0;

    always @(posedge clk0) cyc <= cyc + 1;

    // Macro model: latch command on posedge, act on the following negedge
    always @(posedge clk0) begin
        m_csb  <= sram_csb0;
        m_web  <= sram_web0;
        m_addr <= sram_addr0;
        m_din  <= sram_din0;
    end

    always @(negedge clk0) begin
        if (!m_csb) begin
            if (!m_web) mem[m_addr] <= m_din;
            else        sram_dout0  <= mem[m_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pop on responses, push reads at handshake
    always @(negedge clk0) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else begin
            if (a_rvalid || b_rvalid) begin
                chk("rv_excl", 64'(a_rvalid & b_rvalid), 64'(0));
                if (sb.size() == 0) begin
                    chk("rv_unexpected", 64'(sb.size()), 64'(1));
                end else begin
                    e = sb.pop_front();
                    chk("rv_req", 64'(b_rvalid), 64'(e.req));
                    chk("rv_data", 64'(b_rvalid ? b_rdata : a_rdata),
                        64'(e.data));
                    chk("rv_lat", 64'(cyc - e.hs), 64'(2));
                end
            end
            if (a_ready || b_ready)
                chk("rdy_excl", 64'(a_ready & b_ready), 64'(0));
            if (a_valid && a_ready) begin
                if (a_we) ref_mem[a_addr] = a_wdata;
                else sb.push_back('{1'b0, ref_mem[a_addr], cyc + 1});
            end
            if (b_valid && b_ready) begin
                if (b_we) ref_mem[b_addr] = b_wdata;
                else sb.push_back('{1'b1, ref_mem[b_addr], cyc + 1});
            end
        end
    end

    task automatic init_check();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk0);
            chk("init_csb",  64'(sram_csb0),  64'(0));
            chk("init_web",  64'(sram_web0),  64'(0));
            chk("init_addr", 64'(sram_addr0), 64'(i));
            chk("init_din",  64'(sram_din0),  64'(0));
            chk("init_done", 64'(init_done),  64'(i == DEPTH - 1));
            chk("init_ardy", 64'(a_ready),    64'(i == DEPTH - 1));
            chk("init_brdy", 64'(b_ready),    64'(0));
        end
    endtask

    task automatic idle();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic issue(input bit isb, input bit we,
                         input logic [AW-1:0] addr,
                         input logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        if (isb) begin
            b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = d;
        end else begin
            a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = d;
        end
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk0);
            got = isb ? b_ready : a_ready;
        end
        chk("handshake", 64'(got), 64'(1));
        @(posedge clk0);
        #1;
        if (got) begin
            chk("iss_csb",  64'(sram_csb0),  64'(0));
            chk("iss_web",  64'(sram_web0),  64'(!we));
            chk("iss_addr", 64'(sram_addr0), 64'(addr));
            if (we) chk("iss_din", 64'(sram_din0), 64'(d));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 10) begin
            @(posedge clk0);
            #1;
            t++;
        end
        chk("drain", 64'(sb.size()), 64'(0));
        repeat (2) @(posedge clk0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset values, with A already requesting a read of 0x55
        a_valid = 1'b1; a_we = 1'b0; a_addr = 7'h55;
        repeat (3) @(posedge clk0);
        #1;
        chk("rst_csb",   64'(sram_csb0),  64'(1));
        chk("rst_web",   64'(sram_web0),  64'(1));
        chk("rst_addr",  64'(sram_addr0), 64'(0));
        chk("rst_din",   64'(sram_din0),  64'(0));
        chk("rst_ardy",  64'(a_ready),    64'(0));
        chk("rst_rv",    64'({a_rvalid, b_rvalid}), 64'(0));
        chk("rst_rdata", 64'({a_rdata, b_rdata}),   64'(0));
        chk("rst_done",  64'(init_done),  64'(0));
        rst_n = 1'b1;
        @(posedge clk0);
        init_check();
        @(posedge clk0);
        #1;
        chk("r55_csb",  64'(sram_csb0),  64'(0));
        chk("r55_addr", 64'(sram_addr0), 64'(7'h55));
        idle();
        drain();

        // Write then read the same address on consecutive cycles
        issue(1'b0, 1'b1, 7'h10, 32'hDEAD_BEEF);
        issue(1'b0, 1'b0, 7'h10, 32'h0);
        idle();
        drain();

        // Seed 0x01/0x02, leaving the pointer favouring B
        issue(1'b1, 1'b1, 7'h02, 32'h2222_2222);
        idle();
        issue(1'b0, 1'b1, 7'h01, 32'h1111_1111);
        idle();

        // B alone three times, then both contend and alternate from A
        b_valid = 1'b1; b_we = 1'b0; b_addr = 7'h02;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk0);
            chk("bonly_b", 64'(b_ready), 64'(1));
            chk("bonly_a", 64'(a_ready), 64'(0));
            @(posedge clk0);
            #1;
        end
        a_valid = 1'b1; a_we = 1'b0; a_addr = 7'h01;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk0);
            chk("alt_a", 64'(a_ready), 64'(k % 2 == 0));
            chk("alt_b", 64'(b_ready), 64'(k % 2 == 1));
            @(posedge clk0);
            #1;
        end
        idle();
        drain();

        // Back-to-back reads at both ends of the address range
        issue(1'b0, 1'b1, 7'h7F, 32'hCAFE_0001);
        issue(1'b0, 1'b1, 7'h00, 32'h0BAD_F00D);
        issue(1'b0, 1'b0, 7'h7F, 32'h0);
        issue(1'b0, 1'b0, 7'h00, 32'h0);
        issue(1'b0, 1'b0, 7'h7F, 32'h0);
        idle();
        drain();

        // Reset with two reads in flight
        issue(1'b0, 1'b0, 7'h10, 32'h0);
        issue(1'b0, 1'b0, 7'h7F, 32'h0);
        idle();
        rst_n = 1'b0;
        #1;
        chk("mid_csb",  64'(sram_csb0), 64'(1));
        chk("mid_web",  64'(sram_web0), 64'(1));
        chk("mid_done", 64'(init_done), 64'(0));
        a_valid = 1'b1; a_we = 1'b0; a_addr = 7'h10;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 7'h7F;
        repeat (2) @(posedge clk0);
        #1;
        chk("mid_rv", 64'({a_rvalid, b_rvalid}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk0);
        init_check();
        @(posedge clk0);
        #1;
        a_valid = 1'b0;
        @(negedge clk0);
        chk("post_b", 64'(b_ready), 64'(1));
        @(posedge clk0);
        #1;
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
